// File: rtl/traffic_sensor_conditioner_pkg.sv
// Shared types and default timing constants for the traffic sensor conditioner.
package traffic_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      SERVED = 2'd2
   } lane_state_t;

   localparam int DEBOUNCE_CYCLES_DEF = 16;
   localparam int STUCK_CYCLES_DEF    = 4096;

endpackage

// File: rtl/traffic_sensor_conditioner_if.sv
// Sensor / light-FSM signal bundle. The master is the side that owns the
// detectors and green lamps; the slave is the conditioner.
interface traffic_sensor_conditioner_if;

   logic raw_a;
   logic raw_b;
   logic ga;
   logic gb;
   logic sa;
   logic sb;
   logic fault_a;
   logic fault_b;

   modport master (output raw_a, raw_b, ga, gb,
                   input  sa, sb, fault_a, fault_b);

   modport slave  (input  raw_a, raw_b, ga, gb,
                   output sa, sb, fault_a, fault_b);

endinterface

// File: rtl/sensor_lane_filter.sv
// One lane: 2-flop synchroniser, debounce filter, request latch FSM and
// stuck-sensor detector. Request and fault outputs are registered.
module sensor_lane_filter
   import traffic_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   input  logic green_i,
   output logic s_o,
   output logic fault_o
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int SW = $clog2(STUCK_CYCLES + 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [SW-1:0] STK_MAX  = SW'(STUCK_CYCLES);

   logic          sync1_q, sync2_q;
   logic          filt_q, filt_d;
   logic [DW-1:0] deb_cnt_q, deb_cnt_d;
   lane_state_t   state_q, state_d;
   logic [SW-1:0] stk_cnt_q, stk_cnt_d;
   logic          fault_q, fault_d;
   logic          s_q, s_d;

   // Debounce: filtered level flips only after DEBOUNCE_CYCLES disagreeing samples in a row
   always_comb begin
      filt_d    = filt_q;
      deb_cnt_d = '0;
      if (sync2_q != filt_q) begin
         if (deb_cnt_q == DEB_LAST) filt_d = ~filt_q;
         else                       deb_cnt_d = deb_cnt_q + 1'b1;
      end
   end

   // Lane FSM next state: the REQ latch holds the vehicle until its green arrives
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (filt_q && !green_i) state_d = REQ;
         REQ:     if (green_i)            state_d = SERVED;
         SERVED:  if (!green_i)           state_d = filt_q ? REQ : IDLE;
         default:                         state_d = IDLE;
      endcase
   end

   // Stuck detector and output: a saturated high-time sets a sticky fault that forces s
   always_comb begin
      if (!filt_q)                 stk_cnt_d = '0;
      else if (stk_cnt_q == STK_MAX) stk_cnt_d = stk_cnt_q;
      else                         stk_cnt_d = stk_cnt_q + 1'b1;
      fault_d = fault_q | (stk_cnt_d == STK_MAX);
      s_d     = fault_d | (state_d == REQ);
   end

   // All lane state, cleared asynchronously so a pending request is dropped on reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         filt_q    <= 1'b0;
         deb_cnt_q <= '0;
         state_q   <= IDLE;
         stk_cnt_q <= '0;
         fault_q   <= 1'b0;
         s_q       <= 1'b0;
      end else begin
         sync1_q   <= raw_i;
         sync2_q   <= sync1_q;
         filt_q    <= filt_d;
         deb_cnt_q <= deb_cnt_d;
         state_q   <= state_d;
         stk_cnt_q <= stk_cnt_d;
         fault_q   <= fault_d;
         s_q       <= s_d;
      end
   end

   assign s_o     = s_q;
   assign fault_o = fault_q;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions raw loop-detector inputs into clean Sa/Sb requests for the
// two-way light FSM. Two independent, identical lanes; wiring only.
module traffic_sensor_conditioner
   import traffic_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   traffic_sensor_conditioner_if.slave   bus
);

   sensor_lane_filter #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STUCK_CYCLES    (STUCK_CYCLES)
   ) u_lane_a (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (bus.raw_a),
      .green_i (bus.ga),
      .s_o     (bus.sa),
      .fault_o (bus.fault_a)
   );

   sensor_lane_filter #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STUCK_CYCLES    (STUCK_CYCLES)
   ) u_lane_b (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (bus.raw_b),
      .green_i (bus.gb),
      .s_o     (bus.sb),
      .fault_o (bus.fault_b)
   );

endmodule
